// File: rtl/task_dispatcher.sv
// Frame-based task dispatcher: fetches FRAME_LEN-word frames from program memory and broadcasts
// the instruction words to the cores selected by each frame's header. Optional WAIT-cycle counter under TASK_DISPATCHER_STALL_CNT_EN.
module task_dispatcher #(
  parameter int CORE_NUM  = 16,
  parameter int INSTR_W   = 16,
  parameter int FRAME_LEN = 16,
  parameter int ADDR_W    = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   prog_base,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [INSTR_W-1:0]  mem_rdata,
  input  logic [CORE_NUM-1:0] core_ready,
  input  logic [CORE_NUM-1:0] core_ack,
  output logic [INSTR_W-1:0]  instr_out,
  output logic                instr_valid,
  output logic [CORE_NUM-1:0] core_mask,
  output logic                busy,
  output logic                done
`ifdef TASK_DISPATCHER_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  localparam int OFF_W = $clog2(FRAME_LEN);
  localparam int CNT_W = OFF_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   fp_q, fp_d;
  logic [CORE_NUM-1:0] mask_q, mask_d;
  logic [CORE_NUM-1:0] outst_q, outst_d;
  logic [INSTR_W-1:0]  frame_q [FRAME_LEN];
  logic [INSTR_W-1:0]  frame_d [FRAME_LEN];

  logic [CORE_NUM-1:0] set_vec;
  logic [CORE_NUM-1:0] hdr_mask;
  logic [OFF_W-1:0]    wr_idx;
  logic [OFF_W-1:0]    rd_idx;

  assign hdr_mask = frame_q[0][CORE_NUM-1:0];
  // Read data lags the strobe by one cycle, so the word landing now belongs to the previous address.
  assign wr_idx   = OFF_W'(cnt_q - 1'b1);
  assign rd_idx   = cnt_q[OFF_W-1:0] + OFF_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fp_d        = fp_q;
    mask_d      = mask_q;
    frame_d     = frame_q;
    set_vec     = '0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    instr_out   = '0;
    instr_valid = 1'b0;
    core_mask   = '0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          fp_d    = prog_base & ~ADDR_W'(FRAME_LEN - 1);
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (cnt_q < CNT_W'(FRAME_LEN)) begin
          mem_rd_en = 1'b1;
          mem_addr  = fp_q + ADDR_W'(cnt_q);
        end
        if (cnt_q != '0) begin
          frame_d[wr_idx] = mem_rdata;
        end
        if (cnt_q == CNT_W'(FRAME_LEN)) begin
          cnt_d = '0;
          if (hdr_mask == '0) begin
            state_d = S_DRAIN;
          end else begin
            mask_d  = hdr_mask;
            state_d = S_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (((mask_q & outst_q) == '0) && ((core_ready & mask_q) == mask_q)) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        instr_out   = frame_q[rd_idx];
        core_mask   = mask_q;
        if (cnt_q == '0) begin
          set_vec = mask_q;
        end
        if (cnt_q == CNT_W'(FRAME_LEN - 2)) begin
          cnt_d   = '0;
          fp_d    = fp_q + ADDR_W'(FRAME_LEN);
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (outst_q == '0) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new issue beats a coincident ack so the fresh task is never lost.
    outst_d = (outst_q & ~core_ack) | set_vec;
  end

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fp_q    <= '0;
      mask_q  <= '0;
      outst_q <= '0;
      frame_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fp_q    <= fp_d;
      mask_q  <= mask_d;
      outst_q <= outst_d;
      frame_q <= frame_d;
    end
  end

`ifdef TASK_DISPATCHER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = '0;
    end else if (state_q == S_WAIT && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher: inputs driven and outputs sampled on the falling clock edge,
// program memory modelled with one-cycle read latency; word at address a holds 0xA000|a unless it is a header.
module tb_task_dispatcher;
  localparam int CORE_NUM  = 16;
  localparam int INSTR_W   = 16;
  localparam int FRAME_LEN = 16;
  localparam int ADDR_W    = 10;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [ADDR_W-1:0]   prog_base;
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [INSTR_W-1:0]  mem_rdata;
  logic [CORE_NUM-1:0] core_ready;
  logic [CORE_NUM-1:0] core_ack;
  logic [INSTR_W-1:0]  instr_out;
  logic                instr_valid;
  logic [CORE_NUM-1:0] core_mask;
  logic                busy;
  logic                done;
`ifdef TASK_DISPATCHER_STALL_CNT_EN
  logic [31:0]         stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [INSTR_W-1:0] mem [1 << ADDR_W];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task_dispatcher #(
    .CORE_NUM(CORE_NUM), .INSTR_W(INSTR_W), .FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .prog_base(prog_base),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .core_ready(core_ready), .core_ack(core_ack),
    .instr_out(instr_out), .instr_valid(instr_valid), .core_mask(core_mask),
    .busy(busy), .done(done)
`ifdef TASK_DISPATCHER_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; core_ack = '0; core_ready = '1; prog_base = '0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; core_ack = '0; core_ready = '1; prog_base = '0;
    tick; tick;
    n_cmp++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); end
    n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 000", mem_addr); end
    n_cmp++; if (instr_out !== '0) begin n_err++; $display("FAIL reset_instr_out: got %h want 0000", instr_out); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_cmp++; if (core_mask !== '0) begin n_err++; $display("FAIL reset_core_mask: got %h want 0000", core_mask); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
`ifdef TASK_DISPATCHER_STALL_CNT_EN
    n_cmp++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
`endif
    reset = 1'b0;
  endtask

  // Program at 0x000: one frame for cores 0,1 then an empty header.
  task automatic test_basic;
    int dones;
    do_reset;
    mem[10'h000] = 16'h0003; mem[10'h010] = 16'h0000;
    prog_base = 10'h000; start = 1'b1; tick; start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
    for (int k = 0; k < FRAME_LEN; k++) begin
      n_cmp++;
      if (mem_rd_en !== 1'b1 || mem_addr !== ADDR_W'(k)) begin
        n_err++; $display("FAIL basic_fetch[%0d]: got en=%b addr=%h want en=1 addr=%h", k, mem_rd_en, mem_addr, k);
      end
      tick;
    end
    n_cmp++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL basic_fetch_tail: got en=%b want 0", mem_rd_en); end
    tick;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL basic_wait_cycle: got valid=%b want 0", instr_valid); end
    tick;
    for (int k = 1; k < FRAME_LEN; k++) begin
      n_cmp++;
      if (instr_valid !== 1'b1 || core_mask !== 16'h0003 || instr_out !== (16'hA000 | 16'(k))) begin
        n_err++; $display("FAIL basic_issue[%0d]: got v=%b m=%h d=%h want v=1 m=0003 d=%h",
                          k, instr_valid, core_mask, instr_out, 16'hA000 | 16'(k));
      end
      tick;
    end
    n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 10'h010) begin n_err++; $display("FAIL basic_next_frame: got en=%b addr=%h want en=1 addr=010", mem_rd_en, mem_addr); end
    dones = 0;
    repeat (20) begin tick; if (done === 1'b1) dones++; end
    n_cmp++; if (dones !== 0 || busy !== 1'b1) begin n_err++; $display("FAIL basic_drain_hold: got dones=%0d busy=%b want 0 1", dones, busy); end
    core_ack = 16'h0001; tick; core_ack = '0;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_partial_ack: got done=%b want 0", done); end
    core_ack = 16'h0002; tick; core_ack = '0;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done: got done=%b want 1", done); end
    tick;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  // Frame at 0x40 to core 0, frame at 0x50 to cores 0,1 held until core 0 acks.
  task automatic test_stall;
    int dones;
    do_reset;
    mem[10'h040] = 16'h0001; mem[10'h050] = 16'h0003; mem[10'h060] = 16'h0000;
    prog_base = 10'h040; start = 1'b1; tick; start = 1'b0;
    repeat (18) tick;
    n_cmp++; if (instr_valid !== 1'b1 || core_mask !== 16'h0001 || instr_out !== 16'hA041) begin
      n_err++; $display("FAIL stall_first_issue: got v=%b m=%h d=%h want 1 0001 A041", instr_valid, core_mask, instr_out); end
    repeat (34) tick;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL stall_held: got valid=%b want 0", instr_valid); end
    core_ack = 16'h0001; tick; core_ack = '0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL stall_ack_cycle: got valid=%b want 0", instr_valid); end
    tick;
    n_cmp++; if (instr_valid !== 1'b1 || core_mask !== 16'h0003 || instr_out !== 16'hA051) begin
      n_err++; $display("FAIL stall_release: got v=%b m=%h d=%h want 1 0003 A051", instr_valid, core_mask, instr_out); end
`ifdef TASK_DISPATCHER_STALL_CNT_EN
    n_cmp++; if (stall_cycles !== 32'd5) begin n_err++; $display("FAIL stall_count: got %0d want 5", stall_cycles); end
`endif
    repeat (15) tick;
    core_ack = 16'h0003; tick; core_ack = '0;
    dones = 0;
    repeat (40) begin if (done === 1'b1) dones++; tick; end
    n_cmp++; if (dones !== 1 || busy !== 1'b0) begin n_err++; $display("FAIL stall_done: got dones=%0d busy=%b want 1 0", dones, busy); end
`ifdef TASK_DISPATCHER_STALL_CNT_EN
    n_cmp++; if (stall_cycles !== 32'd5) begin n_err++; $display("FAIL stall_count_end: got %0d want 5", stall_cycles); end
`endif
  endtask

  // Unaligned base 0x3F5 runs from 0x3F0 and the following fetch wraps to 0x000.
  task automatic test_wrap;
    int dones;
    do_reset;
    mem[10'h3F0] = 16'h0010; mem[10'h000] = 16'h0000;
    prog_base = 10'h3F5; start = 1'b1; tick; start = 1'b0;
    n_cmp++; if (mem_addr !== 10'h3F0) begin n_err++; $display("FAIL wrap_base_align: got %h want 3F0", mem_addr); end
    repeat (18) tick;
    n_cmp++; if (instr_valid !== 1'b1 || core_mask !== 16'h0010 || instr_out !== 16'hA3F1) begin
      n_err++; $display("FAIL wrap_issue: got v=%b m=%h d=%h want 1 0010 A3F1", instr_valid, core_mask, instr_out); end
    repeat (15) tick;
    n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 10'h000) begin n_err++; $display("FAIL wrap_addr: got en=%b addr=%h want 1 000", mem_rd_en, mem_addr); end
    core_ack = 16'h0010; tick; core_ack = '0;
    dones = 0;
    repeat (40) begin if (done === 1'b1) dones++; tick; end
    n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL wrap_done: got dones=%0d want 1", dones); end
  endtask

  // Reset during the 5th ISSUE beat, then an empty program must finish without any ack.
  task automatic test_reset_mid;
    do_reset;
    mem[10'h080] = 16'h0005; mem[10'h0A0] = 16'h0000;
    prog_base = 10'h080; start = 1'b1; tick; start = 1'b0;
    repeat (22) tick;
    n_cmp++; if (instr_valid !== 1'b1 || instr_out !== 16'hA085) begin n_err++; $display("FAIL rmid_beat5: got v=%b d=%h want 1 A085", instr_valid, instr_out); end
    reset = 1'b1; tick;
    n_cmp++; if (instr_valid !== 1'b0 || busy !== 1'b0 || core_mask !== '0 || mem_rd_en !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL rmid_cleared: got v=%b busy=%b m=%h en=%b done=%b want all 0", instr_valid, busy, core_mask, mem_rd_en, done); end
    reset = 1'b0; prog_base = 10'h0A0; start = 1'b1; tick; start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || mem_addr !== 10'h0A0) begin n_err++; $display("FAIL rmid_restart: got busy=%b addr=%h want 1 0A0", busy, mem_addr); end
    repeat (17) tick;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rmid_outst_clear: got done=%b want 1", done); end
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_idle: got busy=%b want 0", busy); end
  endtask

  // Ack for core 2 coincides with its first ISSUE beat: bit stays outstanding.
  task automatic test_ack_collide;
    int dones;
    do_reset;
    mem[10'h0C0] = 16'h0004; mem[10'h0D0] = 16'h0000;
    prog_base = 10'h0C0; start = 1'b1; tick; start = 1'b0;
    repeat (18) tick;
    n_cmp++; if (instr_valid !== 1'b1 || core_mask !== 16'h0004) begin n_err++; $display("FAIL collide_issue: got v=%b m=%h want 1 0004", instr_valid, core_mask); end
    core_ack = 16'h0004; tick; core_ack = '0;
    dones = 0;
    repeat (40) begin if (done === 1'b1) dones++; tick; end
    n_cmp++; if (dones !== 0 || busy !== 1'b1) begin n_err++; $display("FAIL collide_blocked: got dones=%0d busy=%b want 0 1", dones, busy); end
    core_ack = 16'h0004; tick; core_ack = '0;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL collide_done: got done=%b want 1", done); end
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL collide_idle: got busy=%b want 0", busy); end
  endtask

  // Second start during FETCH must neither move the pointer nor add a done.
  task automatic test_start_ignore;
    int dones;
    int first_done;
    do_reset;
    mem[10'h0E0] = 16'h0000; mem[10'h100] = 16'h0000;
    prog_base = 10'h0E0; start = 1'b1; tick; start = 1'b0;
    tick; tick;
    start = 1'b1; prog_base = 10'h100; tick; start = 1'b0;
    n_cmp++; if (mem_addr !== 10'h0E3) begin n_err++; $display("FAIL ignore_addr: got %h want 0E3", mem_addr); end
    dones = 0; first_done = -1;
    for (int i = 4; i < 64; i++) begin
      if (done === 1'b1) begin dones++; if (first_done < 0) first_done = i; end
      tick;
    end
    n_cmp++; if (dones !== 1 || first_done !== 18) begin n_err++; $display("FAIL ignore_done: got dones=%0d at=%0d want 1 at 18", dones, first_done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_idle: got busy=%b want 0", busy); end
  endtask

  initial begin
    mem_rdata = '0;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 16'hA000 | 16'(a);
    test_reset;
    test_basic;
    test_stall;
    test_wrap;
    test_reset_mid;
    test_ack_collide;
    test_start_ignore;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/task_dispatcher.md
TASK_DISPATCHER -- requirements
Module: task_dispatcher

Interface
REQ-001 Parameter CORE_NUM, 16, number of cores; 1..INSTR_W.
REQ-002 Parameter INSTR_W, 16, instruction/word width.
REQ-003 Parameter FRAME_LEN, 16, words per frame (power of two, >=2); word 0 header, words 1..FRAME_LEN-1 instructions.
REQ-004 Parameter ADDR_W, 10, program memory address width.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 start  input  1  begin program at prog_base; sampled only in IDLE.
REQ-008 prog_base  input  ADDR_W  first frame address; low log2(FRAME_LEN) bits ignored (treated as zero).
REQ-009 mem_rd_en  output  1  program memory read strobe.
REQ-010 mem_addr  output  ADDR_W  program memory read address.
REQ-011 mem_rdata  input  INSTR_W  read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 core_ready  input  CORE_NUM  per-core ready to accept a task.
REQ-013 core_ack  input  CORE_NUM  per-core one-cycle pulse: task finished.
REQ-014 instr_out  output  INSTR_W  instruction broadcast.
REQ-015 instr_valid  output  1  instr_out valid this cycle.
REQ-016 core_mask  output  CORE_NUM  target cores of the current instr_out; zero when instr_valid low.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse at program end.

Function
REQ-019 States: IDLE, FETCH, WAIT, ISSUE, DRAIN.
REQ-020 IDLE: start=1 -> FETCH next cycle; frame pointer := prog_base.
REQ-021 FETCH: mem_rd_en high for FRAME_LEN consecutive cycles, mem_addr = frame pointer + i (i=0..FRAME_LEN-1); returned words stored in frame buffer; FETCH lasts FRAME_LEN+1 cycles.
REQ-022 After FETCH: header low CORE_NUM bits == 0 -> DRAIN; otherwise task mask := those bits, -> WAIT.
REQ-023 Outstanding register (CORE_NUM bits): bit set when its core is issued a task, cleared on core_ack.
REQ-024 Same-cycle set and ack on one bit: set wins; ack for a bit not outstanding is ignored.
REQ-025 WAIT -> ISSUE when (mask & outstanding)==0 and (core_ready & mask)==mask, both evaluated in the same cycle; otherwise hold.
REQ-026 ISSUE: FRAME_LEN-1 consecutive cycles with instr_valid=1, instr_out = buffer words 1..FRAME_LEN-1 in order, core_mask = mask; outstanding |= mask on the first ISSUE cycle.
REQ-027 End of ISSUE: frame pointer += FRAME_LEN modulo 2^ADDR_W (wraps 2^ADDR_W-FRAME_LEN -> 0), -> FETCH.
REQ-028 DRAIN: wait until outstanding==0; then done=1 for one cycle, -> IDLE.
REQ-029 Minimum gap between consecutive frames issued: FRAME_LEN+2 cycles (FETCH + one WAIT evaluation cycle).
REQ-030 start outside IDLE has no effect.

Reset
REQ-031 reset forces IDLE, clears outputs (mem_rd_en, mem_addr, instr_out, instr_valid, core_mask, busy, done = 0), clears outstanding, frame pointer and buffer, in any state including mid-FETCH or mid-ISSUE.
REQ-032 First cycle after reset deassertion: IDLE; start is accepted.

Configuration
REQ-033 Macro TASK_DISPATCHER_STALL_CNT_EN defined: extra output stall_cycles (32 bits) counts cycles spent in WAIT, saturates at 2^32-1, cleared by reset and on start acceptance.
REQ-034 Macro not defined: port stall_cycles and counter absent; all other behaviour identical.

Verification
REQ-035 prog_base=0x000, frame0 header 0x0003, frame1 header 0, core_ready all 1 -> words 1..15 of frame0 issued with core_mask=0x0003; after acks on cores 0,1, done pulses once.
REQ-036 Two frames with headers 0x0001 and 0x0003, core 0 acks 20 cycles after issue -> second frame held in WAIT until the cycle after that ack; stall_cycles (macro on) equals the WAIT-cycle count.
REQ-037 prog_base=0x3F0, frame at 0x3F0 header 0x0010 -> next fetch mem_addr = 0x000.
REQ-038 reset asserted in 5th ISSUE cycle -> next cycle instr_valid=0, busy=0, outstanding cleared; a new start runs normally.
REQ-039 core_ack on bit 2 in same cycle as first ISSUE to mask 0x0004 -> bit 2 remains outstanding; DRAIN blocks until a later ack.
REQ-040 start pulsed during FETCH -> ignored; exactly one done per accepted start.
